// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD wrap counter over START..START+MOD-1 with tick, manual adjust, validated load and carry.
// Optional BCDCNT_ADJ_EDGE_EN: adj_up/adj_dn become level inputs with registered rising-edge detection.
module bcd_wrap_counter #(
   parameter int unsigned MOD   = 24,
   parameter int unsigned START = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       adj_up,
   input  logic       adj_dn,
   input  logic       load,
   input  logic [3:0] ld_tens,
   input  logic [3:0] ld_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry,
   output logic       load_err
);

   localparam int unsigned TOP = START + MOD - 1;
   localparam int unsigned VW  = 8;

   localparam logic [3:0] TOP_TENS   = 4'(TOP / 10);
   localparam logic [3:0] TOP_ONES   = 4'(TOP % 10);
   localparam logic [3:0] START_TENS = 4'(START / 10);
   localparam logic [3:0] START_ONES = 4'(START % 10);

   logic          up_req;
   logic          dn_req;
   logic [VW-1:0] ld_val;
   logic          ld_ok;
   logic          at_top;
   logic          at_start;
   logic [3:0]    tens_n;
   logic [3:0]    ones_n;
   logic          carry_n;
   logic          load_err_n;

`ifdef BCDCNT_ADJ_EDGE_EN
   // *_low resets to 0 so a button held through reset must be released before it can step.
   logic up_low;
   logic dn_low;
   logic up_pls;
   logic dn_pls;

   always_ff @(posedge clk) begin
      if (rst) begin
         up_low <= 1'b0;
         dn_low <= 1'b0;
         up_pls <= 1'b0;
         dn_pls <= 1'b0;
      end else begin
         up_low <= ~adj_up;
         dn_low <= ~adj_dn;
         up_pls <= adj_up & up_low;
         dn_pls <= adj_dn & dn_low;
      end
   end

   assign up_req = up_pls;
   assign dn_req = dn_pls;
`else
   assign up_req = adj_up;
   assign dn_req = adj_dn;
`endif

   assign ld_val   = VW'(ld_tens) * VW'(10) + VW'(ld_ones);
   assign ld_ok    = (ld_tens <= 4'd9) && (ld_ones <= 4'd9) &&
                     (ld_val >= VW'(START)) && (ld_val <= VW'(TOP));
   assign at_top   = (tens == TOP_TENS) && (ones == TOP_ONES);
   assign at_start = (tens == START_TENS) && (ones == START_ONES);

   // Next count: one action per cycle, load > tick > adj_up > adj_dn.
   always_comb begin
      tens_n     = tens;
      ones_n     = ones;
      carry_n    = 1'b0;
      load_err_n = 1'b0;
      if (load) begin
         if (ld_ok) begin
            tens_n = ld_tens;
            ones_n = ld_ones;
         end else begin
            load_err_n = 1'b1;
         end
      end else if (tick || up_req) begin
         carry_n = tick & at_top;
         if (at_top) begin
            tens_n = START_TENS;
            ones_n = START_ONES;
         end else if (ones == 4'd9) begin
            tens_n = tens + 4'd1;
            ones_n = 4'd0;
         end else begin
            ones_n = ones + 4'd1;
         end
      end else if (dn_req) begin
         if (at_start) begin
            tens_n = TOP_TENS;
            ones_n = TOP_ONES;
         end else if (ones == 4'd0) begin
            tens_n = tens - 4'd1;
            ones_n = 4'd9;
         end else begin
            ones_n = ones - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tens     <= START_TENS;
         ones     <= START_ONES;
         carry    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         tens     <= tens_n;
         ones     <= ones_n;
         carry    <= carry_n;
         load_err <= load_err_n;
      end
   end

endmodule

// File: tb/tb_bcd_wrap_counter.sv
// Bench for bcd_wrap_counter: instance 0 is MOD=24/START=0, instance 1 is MOD=12/START=1.
// Honours BCDCNT_ADJ_EDGE_EN for the adjust-related expectations.
module tb_bcd_wrap_counter;

   logic       clk = 1'b0;
   logic       rst, tick, adj_up, adj_dn, load;
   logic [3:0] ld_tens, ld_ones;
   logic [3:0] tens_o [2];
   logic [3:0] ones_o [2];
   logic       carry_o [2];
   logic       err_o [2];

   int checks = 0;
   int errors = 0;

   int m_cnt [2];
   int m_car [2];
   int m_err [2];

   typedef struct {
      logic rst, load, tick, up, dn;
      logic [3:0] lt, lo;
      int v0; logic c0, e0;
      int v1; logic c1, e1;
   } vec_t;

   vec_t tbl [23];

   always #5 clk = ~clk;

   bcd_wrap_counter #(.MOD(24), .START(0)) dut24 (
      .clk(clk), .rst(rst), .tick(tick), .adj_up(adj_up), .adj_dn(adj_dn),
      .load(load), .ld_tens(ld_tens), .ld_ones(ld_ones),
      .tens(tens_o[0]), .ones(ones_o[0]), .carry(carry_o[0]), .load_err(err_o[0])
   );

   bcd_wrap_counter #(.MOD(12), .START(1)) dut12 (
      .clk(clk), .rst(rst), .tick(tick), .adj_up(adj_up), .adj_dn(adj_dn),
      .load(load), .ld_tens(ld_tens), .ld_ones(ld_ones),
      .tens(tens_o[1]), .ones(ones_o[1]), .carry(carry_o[1]), .load_err(err_o[1])
   );

   function automatic vec_t mk(logic r, logic l, logic t, logic u, logic d,
                               logic [3:0] lt, logic [3:0] lo,
                               int v0, logic c0, logic e0, int v1, logic c1, logic e1);
      vec_t v;
      v.rst = r; v.load = l; v.tick = t; v.up = u; v.dn = d; v.lt = lt; v.lo = lo;
      v.v0 = v0; v.c0 = c0; v.e0 = e0; v.v1 = v1; v.c1 = c1; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_dut(string name, int i, int val, int car, int err);
      chk({name, "/tens"}, int'(tens_o[i]), val / 10);
      chk({name, "/ones"}, int'(ones_o[i]), val % 10);
      chk({name, "/carry"}, int'(carry_o[i]), car);
      chk({name, "/load_err"}, int'(err_o[i]), err);
   endtask

   // Counter rules on the plain integer value; adjust inputs are taken as pulses.
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int st, top, v;
         st  = (i == 0) ? 0 : 1;
         top = (i == 0) ? 23 : 12;
         m_car[i] = 0;
         m_err[i] = 0;
         if (rst) begin
            m_cnt[i] = st;
         end else if (load) begin
            v = int'(ld_tens) * 10 + int'(ld_ones);
            if (ld_tens <= 9 && ld_ones <= 9 && v >= st && v <= top) m_cnt[i] = v;
            else m_err[i] = 1;
         end else if (tick || adj_up) begin
            if (m_cnt[i] == top) begin
               m_cnt[i] = st;
               m_car[i] = tick ? 1 : 0;
            end else begin
               m_cnt[i] = m_cnt[i] + 1;
            end
         end else if (adj_dn) begin
            m_cnt[i] = (m_cnt[i] == st) ? top : m_cnt[i] - 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      rst = 0; tick = 0; adj_up = 0; adj_dn = 0; load = 0; ld_tens = 0; ld_ones = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      @(negedge clk);
      step();
      chk_dut("reset24", 0, 0, 0, 0);
      chk_dut("reset12", 1, 1, 0, 0);

`ifndef BCDCNT_ADJ_EDGE_EN
      tbl[0]  = mk(1,0,0,0,0, 4'd0, 4'd0,   0,0,0,  1,0,0);
      tbl[1]  = mk(0,1,0,0,0, 4'd2, 4'd3,  23,0,0,  1,0,1);
      tbl[2]  = mk(0,0,1,0,0, 4'd0, 4'd0,   0,1,0,  2,0,0);
      tbl[3]  = mk(0,1,0,0,0, 4'd2, 4'd4,   0,0,1,  2,0,1);
      tbl[4]  = mk(0,1,0,0,0, 4'd10,4'd5,   0,0,1,  2,0,1);
      tbl[5]  = mk(0,1,1,1,0, 4'd1, 4'd9,  19,0,0,  2,0,1);
      tbl[6]  = mk(0,1,0,0,0, 4'd0, 4'd5,   5,0,0,  5,0,0);
      tbl[7]  = mk(0,0,1,1,0, 4'd0, 4'd0,   6,0,0,  6,0,0);
      tbl[8]  = mk(0,1,0,0,0, 4'd0, 4'd1,   1,0,0,  1,0,0);
      tbl[9]  = mk(0,0,0,0,1, 4'd0, 4'd0,   0,0,0, 12,0,0);
      tbl[10] = mk(0,0,1,0,0, 4'd0, 4'd0,   1,0,0,  1,1,0);
      tbl[11] = mk(0,0,0,0,1, 4'd0, 4'd0,   0,0,0, 12,0,0);
      tbl[12] = mk(0,0,0,0,1, 4'd0, 4'd0,  23,0,0, 11,0,0);
      tbl[13] = mk(1,0,1,0,0, 4'd0, 4'd0,   0,0,0,  1,0,0);
      tbl[14] = mk(0,0,1,0,0, 4'd0, 4'd0,   1,0,0,  2,0,0);
      tbl[15] = mk(0,1,0,0,0, 4'd0, 4'd9,   9,0,0,  9,0,0);
      tbl[16] = mk(0,0,1,0,0, 4'd0, 4'd0,  10,0,0, 10,0,0);
      tbl[17] = mk(0,1,0,0,0, 4'd0, 4'd0,   0,0,0, 10,0,1);
      tbl[18] = mk(0,0,0,1,0, 4'd0, 4'd0,   1,0,0, 11,0,0);
      tbl[19] = mk(0,0,0,1,1, 4'd0, 4'd0,   2,0,0, 12,0,0);
      tbl[20] = mk(0,0,0,1,0, 4'd0, 4'd0,   3,0,0,  1,0,0);
      tbl[21] = mk(0,1,0,0,0, 4'd1, 4'd9,  19,0,0,  1,0,1);
      tbl[22] = mk(0,0,1,0,0, 4'd0, 4'd0,  20,0,0,  2,0,0);
      for (int k = 0; k < 23; k++) begin
         rst = tbl[k].rst; load = tbl[k].load; tick = tbl[k].tick;
         adj_up = tbl[k].up; adj_dn = tbl[k].dn; ld_tens = tbl[k].lt; ld_ones = tbl[k].lo;
         step();
         chk_dut($sformatf("vec%0d_m24", k), 0, tbl[k].v0, int'(tbl[k].c0), int'(tbl[k].e0));
         chk_dut($sformatf("vec%0d_m12", k), 1, tbl[k].v1, int'(tbl[k].c1), int'(tbl[k].e1));
      end
`endif

      // Continuous tick from reset: full wrap on both, carry every MOD cycles.
      idle(); rst = 1; step();
      idle(); tick = 1;
      for (int k = 1; k <= 24; k++) begin
         step();
         chk_dut($sformatf("wrap_k%0d_m24", k), 0, k % 24, (k == 24) ? 1 : 0, 0);
         chk_dut($sformatf("wrap_k%0d_m12", k), 1, 1 + (k % 12), (k % 12 == 0) ? 1 : 0, 0);
      end

      // Adjust-up held for ten cycles from 07.
      idle(); load = 1; ld_tens = 4'd0; ld_ones = 4'd7; step();
      idle(); adj_up = 1;
      for (int k = 0; k < 10; k++) step();
      idle(); step(); step();
`ifdef BCDCNT_ADJ_EDGE_EN
      chk_dut("held_up_m24", 0, 8, 0, 0);
      chk_dut("held_up_m12", 1, 8, 0, 0);
      // Press held through reset must not step after reset releases.
      idle(); adj_up = 1; rst = 1; step(); step();
      rst = 0;
      for (int k = 0; k < 5; k++) step();
      idle(); step(); step();
      chk_dut("held_rst_m24", 0, 0, 0, 0);
      chk_dut("held_rst_m12", 1, 1, 0, 0);
`else
      chk_dut("held_up_m24", 0, 17, 0, 0);
      chk_dut("held_up_m12", 1, 5, 0, 0);
`endif

      // Randomised traffic against the behavioural model.
      idle(); rst = 1; step();
      for (int k = 0; k < 600; k++) begin
         rst     = ($urandom % 60) == 0;
         load    = ($urandom % 8) == 0;
         tick    = ($urandom % 3) == 0;
         ld_tens = 4'($urandom_range(0, 10));
         ld_ones = (($urandom % 16) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
`ifdef BCDCNT_ADJ_EDGE_EN
         adj_up  = 1'b0;
         adj_dn  = 1'b0;
`else
         adj_up  = ($urandom % 4) == 0;
         adj_dn  = ($urandom % 4) == 0;
`endif
         step();
         for (int i = 0; i < 2; i++)
            chk_dut($sformatf("rand%0d_dut%0d", k, i), i, m_cnt[i], m_car[i], m_err[i]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
